// File: rtl/somador_pkg.sv
// Shared constants and elaboration-time helpers for the somador_pipe adder/subtractor.
package somador_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Widest operand the saturation helpers can describe; results are cast down to W.
  localparam int SAT_MAX_W = 1024;

  function automatic int cw(input int w, input int stages);
    return (w + stages - 1) / stages;
  endfunction

  function automatic logic [SAT_MAX_W-1:0] sat_pos(input int w);
    return (SAT_MAX_W'(1) << (w - 1)) - SAT_MAX_W'(1);
  endfunction

  function automatic logic [SAT_MAX_W-1:0] sat_neg(input int w);
    return SAT_MAX_W'(1) << (w - 1);
  endfunction

endpackage

// File: rtl/somador_estagio.sv
// One pipeline stage of somador_pipe: registered chunk adder with carry and valid.
module somador_estagio
  import somador_pkg::*;
#(
  parameter int CW = 22
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_en,
  input  logic [CW-1:0] i_a,
  input  logic [CW-1:0] i_b,
  input  logic          i_cin,
  input  logic          i_valid,
  output logic [CW-1:0] o_sum,
  output logic          o_cout,
  output logic          o_valid
);

  logic [CW:0]   w_add;
  logic [CW-1:0] r_sum;
  logic          r_cout;
  logic          r_valid;

  assign w_add = {1'b0, i_a} + {1'b0, i_b} + {{CW{1'b0}}, i_cin};

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_valid <= 1'b0;
    end else if (i_en) begin
      r_sum   <= w_add[CW-1:0];
      r_cout  <= w_add[CW];
      r_valid <= i_valid;
    end
  end

  assign o_sum   = r_sum;
  assign o_cout  = r_cout;
  assign o_valid = r_valid;

endmodule

// File: rtl/somador_pipe.sv
// Pipelined W-bit adder/subtractor, one carry-chain chunk per stage, valid/ready handshake.
// Build option SOMADOR_SAT_EN: clamp the result to signed saturation on overflow.
module somador_pipe
  import somador_pkg::*;
#(
  parameter int W      = 44,
  parameter int STAGES = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         mode,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] s,
  output logic         carry,
  output logic         overflow
);

  localparam int CW_P = cw(W, STAGES);

  logic         w_adv;
  logic [W-1:0] w_b_eff;
  logic         w_cin0;
  logic [W-1:0] w_s_raw;
  logic         r_amsb;
  logic         r_bmsb;

  // The whole pipe moves or holds as one unit; bubbles stay in place.
  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;

  assign w_b_eff = (mode == MODE_SUB) ? ~b : b;
  assign w_cin0  = (mode == MODE_ADD) ? 1'b0 : 1'b1;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int LO = k * CW_P;
    localparam int HI = ((k + 1) * CW_P > W) ? W : (k + 1) * CW_P;
    localparam int CK = HI - LO;

    // w_ua/w_ub: operand bits not yet consumed, starting with this stage's chunk.
    logic [W-LO-1:0] w_ua;
    logic [W-LO-1:0] w_ub;
    logic [CK-1:0]   w_sum;
    logic [HI-1:0]   w_lo_out;
    logic            w_cin;
    logic            w_vin;
    logic            w_cout;
    logic            w_vout;

    if (k == 0) begin : g_src
      assign w_ua     = a;
      assign w_ub     = w_b_eff;
      assign w_cin    = w_cin0;
      assign w_vin    = in_valid;
      assign w_lo_out = w_sum;
    end else begin : g_src
      logic [LO-1:0] r_lo;

      assign w_ua  = g_st[k-1].g_skew.r_ua;
      assign w_ub  = g_st[k-1].g_skew.r_ub;
      assign w_cin = g_st[k-1].w_cout;
      assign w_vin = g_st[k-1].w_vout;

      always_ff @(posedge clock) begin
        if (reset) begin
          r_lo <= '0;
        end else if (w_adv) begin
          r_lo <= g_st[k-1].w_lo_out;
        end
      end

      assign w_lo_out = {w_sum, r_lo};
    end

    somador_estagio #(.CW(CK)) u_estagio (
      .clock   (clock),
      .reset   (reset),
      .i_en    (w_adv),
      .i_a     (w_ua[CK-1:0]),
      .i_b     (w_ub[CK-1:0]),
      .i_cin   (w_cin),
      .i_valid (w_vin),
      .o_sum   (w_sum),
      .o_cout  (w_cout),
      .o_valid (w_vout)
    );

    if (k < STAGES - 1) begin : g_skew
      logic [W-HI-1:0] r_ua;
      logic [W-HI-1:0] r_ub;

      always_ff @(posedge clock) begin
        if (w_adv) begin
          r_ua <= w_ua[W-LO-1:CK];
          r_ub <= w_ub[W-LO-1:CK];
        end
      end
    end else begin : g_msb
      // Sign bits of the effective operands travel with the top chunk for the flag logic.
      always_ff @(posedge clock) begin
        if (reset) begin
          r_amsb <= 1'b0;
          r_bmsb <= 1'b0;
        end else if (w_adv) begin
          r_amsb <= w_ua[CK-1];
          r_bmsb <= w_ub[CK-1];
        end
      end
    end
  end

  assign w_s_raw   = g_st[STAGES-1].w_lo_out;
  assign carry     = g_st[STAGES-1].w_cout;
  assign out_valid = g_st[STAGES-1].w_vout;
  assign overflow  = (r_amsb == r_bmsb) && (w_s_raw[W-1] != r_amsb);

`ifdef SOMADOR_SAT_EN
  localparam logic [W-1:0] SAT_POS = W'(sat_pos(W));
  localparam logic [W-1:0] SAT_NEG = W'(sat_neg(W));

  assign s = overflow ? (r_amsb ? SAT_NEG : SAT_POS) : w_s_raw;
`else
  assign s = w_s_raw;
`endif

endmodule

// File: tb/tb_somador_pipe.sv
// Self-checking bench for somador_pipe (W=44, STAGES=2): vector table, corner sequences, random scoreboard.
module tb_somador_pipe;

  localparam int W = 44;

  localparam logic [W-1:0] P_MAX = 44'h7FF_FFFF_FFFF;
  localparam logic [W-1:0] N_MIN = 44'h800_0000_0000;
  localparam logic [W-1:0] ONES  = 44'hFFF_FFFF_FFFF;

`ifdef SOMADOR_SAT_EN
  localparam logic [W-1:0] X6 = P_MAX;
  localparam logic [W-1:0] X7 = N_MIN;
  localparam logic [W-1:0] X8 = N_MIN;
  localparam logic [W-1:0] X9 = P_MAX;
`else
  localparam logic [W-1:0] X6 = N_MIN;
  localparam logic [W-1:0] X7 = P_MAX;
  localparam logic [W-1:0] X8 = '0;
  localparam logic [W-1:0] X9 = N_MIN;
`endif

  localparam longint SMAX = (longint'(1) << (W - 1)) - 1;
  localparam longint SMIN = -(longint'(1) << (W - 1));

  logic         clock;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic         mode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s;
  logic         carry;
  logic         overflow;

  somador_pipe #(.W(W), .STAGES(2)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .carry     (carry),
    .overflow  (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic         vm;
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic [W-1:0] es;
    logic         ec;
    logic         eo;
  } vec_t;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } exp_t;

  int checks;
  int failures;
  exp_t q[$];
  logic         hold;
  logic [W-1:0] h_s;
  logic         h_c;
  logic         h_o;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference: signed/unsigned arithmetic on wide integers.
  function automatic exp_t model(input logic m, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    longint sx, sy, r;
    logic [W:0] u;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    r = m ? (sx - sy) : (sx + sy);
    e.o = (r > SMAX) || (r < SMIN);
    e.s = r[W-1:0];
    u = {1'b0, x} + {1'b0, y};
    e.c = m ? (x >= y) : u[W];
`ifdef SOMADOR_SAT_EN
    if (e.o) e.s = (r > 0) ? W'(SMAX) : W'(SMIN);
`endif
    return e;
  endfunction

  task automatic mon_step();
    exp_t e;
    if (reset) begin
      q.delete();
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_s", 64'(s), 64'(h_s));
        chk("hold_carry", 64'(carry), 64'(h_c));
        chk("hold_ovf", 64'(overflow), 64'(h_o));
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out_valid", 64'(out_valid), 64'd0);
        end else if (out_ready) begin
          e = q.pop_front();
          chk("sb_s", 64'(s), 64'(e.s));
          chk("sb_carry", 64'(carry), 64'(e.c));
          chk("sb_ovf", 64'(overflow), 64'(e.o));
        end
      end
      hold = out_valid && !out_ready;
      h_s = s;
      h_c = carry;
      h_o = overflow;
      if (in_valid && in_ready) q.push_back(model(mode, a, b));
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [W-1:0] rand_op();
    logic [63:0] t;
    case ($urandom_range(0, 7))
      0: rand_op = '0;
      1: rand_op = ONES;
      2: rand_op = P_MAX;
      3: rand_op = N_MIN;
      default: begin
        t = {$urandom, $urandom};
        rand_op = t[W-1:0];
      end
    endcase
  endfunction

  vec_t vecs[10];
  logic [W-1:0] got[$];
  int  nacc;
  bit  saw_low;

  initial begin
    vecs[0] = '{1'b0, 44'd4,          44'd8,  44'd12,       1'b0, 1'b0};
    vecs[1] = '{1'b0, 44'd11,         44'd40, 44'd51,       1'b0, 1'b0};
    vecs[2] = '{1'b0, 44'h3F_FFFF,    44'd1,  44'h40_0000,  1'b0, 1'b0};
    vecs[3] = '{1'b0, ONES,           44'd1,  44'd0,        1'b1, 1'b0};
    vecs[4] = '{1'b1, 44'd5,          44'd5,  44'd0,        1'b1, 1'b0};
    vecs[5] = '{1'b1, 44'd4,          44'd5,  ONES,         1'b0, 1'b0};
    vecs[6] = '{1'b0, P_MAX,          44'd1,  X6,           1'b0, 1'b1};
    vecs[7] = '{1'b1, N_MIN,          44'd1,  X7,           1'b1, 1'b1};
    vecs[8] = '{1'b0, N_MIN,          N_MIN,  X8,           1'b1, 1'b1};
    vecs[9] = '{1'b1, 44'd0,          N_MIN,  X9,           1'b0, 1'b1};

    checks = 0;
    failures = 0;
    hold = 1'b0;
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    mode = 1'b0;
    a = '0;
    b = '0;

    fork
      forever begin
        @(negedge clock);
        mon_step();
      end
    join_none

    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_s", 64'(s), 64'd0);
    chk("rst_carry", 64'(carry), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Single beats: latency of two cycles and exact values.
    for (int i = 0; i < 10; i++) begin
      mode = vecs[i].vm;
      a = vecs[i].va;
      b = vecs[i].vb;
      in_valid = 1'b1;
      #1;
      chk($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'd1);
      step();
      in_valid = 1'b0;
      chk($sformatf("v%0d_lat1_valid", i), 64'(out_valid), 64'd0);
      step();
      chk($sformatf("v%0d_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("v%0d_s", i), 64'(s), 64'(vecs[i].es));
      chk($sformatf("v%0d_carry", i), 64'(carry), 64'(vecs[i].ec));
      chk($sformatf("v%0d_ovf", i), 64'(overflow), 64'(vecs[i].eo));
      step();
    end

    // Backpressure: out_ready low for cycles 3..5 of a four-beat stream.
    got.delete();
    nacc = 0;
    saw_low = 1'b0;
    for (int c = 0; c < 30 && got.size() < 4; c++) begin
      out_ready = !(c >= 3 && c <= 5);
      in_valid = (nacc < 4);
      mode = 1'b0;
      a = W'(nacc + 1);
      b = W'(nacc + 1);
      @(negedge clock);
      if (!in_ready) saw_low = 1'b1;
      if (out_valid && out_ready) got.push_back(s);
      if (in_valid && in_ready) nacc++;
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("bp_in_ready_dropped", 64'(saw_low), 64'd1);
    chk("bp_count", 64'(got.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < got.size()) chk($sformatf("bp_out%0d", i), 64'(got[i]), 64'(2 * (i + 1)));
    end
    repeat (3) step();

    // Reset with two beats in flight and a simultaneous accept attempt.
    out_ready = 1'b0;
    mode = 1'b0;
    in_valid = 1'b1;
    a = 44'd100;
    b = 44'd1;
    step();
    a = 44'd200;
    b = 44'd2;
    step();
    chk("rs_inflight_valid", 64'(out_valid), 64'd1);
    reset = 1'b1;
    out_ready = 1'b1;
    a = 44'd300;
    b = 44'd3;
    step();
    reset = 1'b0;
    in_valid = 1'b0;
    chk("rs_out_valid", 64'(out_valid), 64'd0);
    chk("rs_s", 64'(s), 64'd0);
    chk("rs_carry", 64'(carry), 64'd0);
    chk("rs_ovf", 64'(overflow), 64'd0);
    chk("rs_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("rs_no_stale%0d", i), 64'(out_valid), 64'd0);
    end

    // Random traffic against the scoreboard.
    for (int c = 0; c < 400; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      mode = 1'($urandom_range(0, 1));
      a = rand_op();
      b = rand_op();
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && q.size() != 0; c++) step();
    chk("drain_empty", 64'(q.size()), 64'd0);
    step();
    chk("final_out_valid", 64'(out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
